// File: rtl/window_buffer_3x3_if.sv
// -----------------------------------------------------------------------------
// window_buffer_3x3_if
//   Bundles the pixel input stream and the 3x3 window output bus of
//   window_buffer_3x3.
//   Input stream : in_valid, in_sof, in_red/in_green/in_blue
//   Window bus   : pixel_k_red/green/blue (k = 3*wrow + wcol, 0 = top-left,
//                  4 = centre, 8 = bottom-right), window_valid, window_last
//   modport master : pixel source / window sink (e.g. testbench)
//   modport slave  : the window buffer itself
// -----------------------------------------------------------------------------
interface window_buffer_3x3_if #(
    parameter int BIT_PER_PIXEL = 8
);
    logic                     in_valid;
    logic                     in_sof;
    logic [BIT_PER_PIXEL-1:0] in_red;
    logic [BIT_PER_PIXEL-1:0] in_green;
    logic [BIT_PER_PIXEL-1:0] in_blue;

    logic [BIT_PER_PIXEL-1:0] pixel_0_red, pixel_0_green, pixel_0_blue;
    logic [BIT_PER_PIXEL-1:0] pixel_1_red, pixel_1_green, pixel_1_blue;
    logic [BIT_PER_PIXEL-1:0] pixel_2_red, pixel_2_green, pixel_2_blue;
    logic [BIT_PER_PIXEL-1:0] pixel_3_red, pixel_3_green, pixel_3_blue;
    logic [BIT_PER_PIXEL-1:0] pixel_4_red, pixel_4_green, pixel_4_blue;
    logic [BIT_PER_PIXEL-1:0] pixel_5_red, pixel_5_green, pixel_5_blue;
    logic [BIT_PER_PIXEL-1:0] pixel_6_red, pixel_6_green, pixel_6_blue;
    logic [BIT_PER_PIXEL-1:0] pixel_7_red, pixel_7_green, pixel_7_blue;
    logic [BIT_PER_PIXEL-1:0] pixel_8_red, pixel_8_green, pixel_8_blue;

    logic                     window_valid;
    logic                     window_last;

    modport master (
        output in_valid, in_sof, in_red, in_green, in_blue,
        input  pixel_0_red, pixel_0_green, pixel_0_blue,
        input  pixel_1_red, pixel_1_green, pixel_1_blue,
        input  pixel_2_red, pixel_2_green, pixel_2_blue,
        input  pixel_3_red, pixel_3_green, pixel_3_blue,
        input  pixel_4_red, pixel_4_green, pixel_4_blue,
        input  pixel_5_red, pixel_5_green, pixel_5_blue,
        input  pixel_6_red, pixel_6_green, pixel_6_blue,
        input  pixel_7_red, pixel_7_green, pixel_7_blue,
        input  pixel_8_red, pixel_8_green, pixel_8_blue,
        input  window_valid, window_last
    );

    modport slave (
        input  in_valid, in_sof, in_red, in_green, in_blue,
        output pixel_0_red, pixel_0_green, pixel_0_blue,
        output pixel_1_red, pixel_1_green, pixel_1_blue,
        output pixel_2_red, pixel_2_green, pixel_2_blue,
        output pixel_3_red, pixel_3_green, pixel_3_blue,
        output pixel_4_red, pixel_4_green, pixel_4_blue,
        output pixel_5_red, pixel_5_green, pixel_5_blue,
        output pixel_6_red, pixel_6_green, pixel_6_blue,
        output pixel_7_red, pixel_7_green, pixel_7_blue,
        output pixel_8_red, pixel_8_green, pixel_8_blue,
        output window_valid, window_last
    );
endinterface

// File: rtl/window_buffer_3x3.sv
// -----------------------------------------------------------------------------
// window_buffer_3x3
//   Takes a raster-order RGB pixel stream (at most one pixel per clock, no
//   backpressure), keeps the two previous rows in line buffers and presents
//   the 3x3 neighbourhood of every interior pixel as 27 parallel channels.
//   Ports:
//     clk  - single rising-edge clock
//     rst  - asynchronous active-high reset (counters, window, flags to 0)
//     bus  - window_buffer_3x3_if.slave: in_valid/in_sof/in_* stream in,
//            pixel_k_* window, window_valid pulse, window_last out
//   Compile-time option:
//     WINDOW_OUT_REG_EN - adds one register stage on every output
//                         (latency 2 clk instead of 1 clk).
// -----------------------------------------------------------------------------
module window_buffer_3x3 #(
    parameter int BIT_PER_PIXEL = 8,
    parameter int IMG_WIDTH     = 320,
    parameter int IMG_HEIGHT    = 240
) (
    input  logic                clk,
    input  logic                rst,
    window_buffer_3x3_if.slave  bus
);
    localparam int PW = 3 * BIT_PER_PIXEL;
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [CW-1:0] COL_ZERO = {CW{1'b0}};
    localparam logic [RW-1:0] ROW_ZERO = {RW{1'b0}};
    localparam logic [CW-1:0] COL_ONE  = CW'(1);
    localparam logic [RW-1:0] ROW_ONE  = RW'(1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);
    localparam logic [PW-1:0] PX_ZERO  = {PW{1'b0}};

    // Pixels are packed {red, green, blue}.
    logic [PW-1:0] in_px_s;
    logic          accept_s;
    logic [CW-1:0] col_r, col_s;
    logic [RW-1:0] row_r, row_s;

    logic [PW-1:0] lb_a [0:IMG_WIDTH-1];   // row r-1
    logic [PW-1:0] lb_b [0:IMG_WIDTH-1];   // row r-2
    logic [PW-1:0] lb_a_rd_s;
    logic [PW-1:0] lb_b_rd_s;

    logic [PW-1:0] win_r [0:8];
    logic          valid_r;
    logic          last_r;

    logic [PW-1:0] out_win_s [0:8];
    logic          out_valid_s;
    logic          out_last_s;

    // Effective position of the incoming pixel: sof forces (0,0) so a
    // restart takes effect on the very pixel that carries it.
    always_comb begin
        accept_s = bus.in_valid;
        in_px_s  = {bus.in_red, bus.in_green, bus.in_blue};
        if (bus.in_sof) begin
            col_s = COL_ZERO;
            row_s = ROW_ZERO;
        end else begin
            col_s = col_r;
            row_s = row_r;
        end
    end

    // Raster position counters; wrap at end of frame so frames chain without sof.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_r <= COL_ZERO;
            row_r <= ROW_ZERO;
        end else if (accept_s) begin
            if (col_s == COL_LAST) begin
                col_r <= COL_ZERO;
                if (row_s == ROW_LAST) begin
                    row_r <= ROW_ZERO;
                end else begin
                    row_r <= row_s + ROW_ONE;
                end
            end else begin
                col_r <= col_s + COL_ONE;
                row_r <= row_s;
            end
        end
    end

    // Line buffer read port: old contents of column c, before this cycle's write.
    always_comb begin
        lb_a_rd_s = lb_a[col_s];
        lb_b_rd_s = lb_b[col_s];
    end

    // Line buffer write: row r-1 ages into row r-2, incoming pixel becomes row r-1.
    // Contents are deliberately not reset; stale data is overwritten before use.
    always_ff @(posedge clk) begin
        if (accept_s) begin
            lb_b[col_s] <= lb_a_rd_s;
            lb_a[col_s] <= in_px_s;
        end
    end

    // 3x3 window: shift one column left per accept, new right column from
    // the line buffers and the input pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                win_r[k] <= PX_ZERO;
            end
        end else if (accept_s) begin
            win_r[0] <= win_r[1];
            win_r[1] <= win_r[2];
            win_r[2] <= lb_b_rd_s;
            win_r[3] <= win_r[4];
            win_r[4] <= win_r[5];
            win_r[5] <= lb_a_rd_s;
            win_r[6] <= win_r[7];
            win_r[7] <= win_r[8];
            win_r[8] <= in_px_s;
        end
    end

    // Window flags: only interior centres (r>=2, c>=2 on the right column)
    // qualify, so windows never straddle rows.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_r <= 1'b0;
            last_r  <= 1'b0;
        end else begin
            valid_r <= accept_s && (row_s >= ROW_TWO) && (col_s >= COL_TWO);
            last_r  <= accept_s && (row_s == ROW_LAST) && (col_s == COL_LAST);
        end
    end

`ifdef WINDOW_OUT_REG_EN
    logic [PW-1:0] out_win_r [0:8];
    logic          out_valid_r;
    logic          out_last_r;

    // Extra output stage: same sequence delayed by one clock.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 9; k++) begin
                out_win_r[k] <= PX_ZERO;
            end
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else begin
            for (int k = 0; k < 9; k++) begin
                out_win_r[k] <= win_r[k];
            end
            out_valid_r <= valid_r;
            out_last_r  <= last_r;
        end
    end

    // Select the delayed copy as the output source.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            out_win_s[k] = out_win_r[k];
        end
        out_valid_s = out_valid_r;
        out_last_s  = out_last_r;
    end
`else
    // Outputs come straight from the window registers and flag flops.
    always_comb begin
        for (int k = 0; k < 9; k++) begin
            out_win_s[k] = win_r[k];
        end
        out_valid_s = valid_r;
        out_last_s  = last_r;
    end
`endif

    assign bus.window_valid = out_valid_s;
    assign bus.window_last  = out_last_s;

    assign bus.pixel_0_red   = out_win_s[0][PW-1 -: BIT_PER_PIXEL];
    assign bus.pixel_0_green = out_win_s[0][2*BIT_PER_PIXEL-1 -: BIT_PER_PIXEL];
    assign bus.pixel_0_blue  = out_win_s[0][BIT_PER_PIXEL-1:0];
    assign bus.pixel_1_red   = out_win_s[1][PW-1 -: BIT_PER_PIXEL];
    assign bus.pixel_1_green = out_win_s[1][2*BIT_PER_PIXEL-1 -: BIT_PER_PIXEL];
    assign bus.pixel_1_blue  = out_win_s[1][BIT_PER_PIXEL-1:0];
    assign bus.pixel_2_red   = out_win_s[2][PW-1 -: BIT_PER_PIXEL];
    assign bus.pixel_2_green = out_win_s[2][2*BIT_PER_PIXEL-1 -: BIT_PER_PIXEL];
    assign bus.pixel_2_blue  = out_win_s[2][BIT_PER_PIXEL-1:0];
    assign bus.pixel_3_red   = out_win_s[3][PW-1 -: BIT_PER_PIXEL];
    assign bus.pixel_3_green = out_win_s[3][2*BIT_PER_PIXEL-1 -: BIT_PER_PIXEL];
    assign bus.pixel_3_blue  = out_win_s[3][BIT_PER_PIXEL-1:0];
    assign bus.pixel_4_red   = out_win_s[4][PW-1 -: BIT_PER_PIXEL];
    assign bus.pixel_4_green = out_win_s[4][2*BIT_PER_PIXEL-1 -: BIT_PER_PIXEL];
    assign bus.pixel_4_blue  = out_win_s[4][BIT_PER_PIXEL-1:0];
    assign bus.pixel_5_red   = out_win_s[5][PW-1 -: BIT_PER_PIXEL];
    assign bus.pixel_5_green = out_win_s[5][2*BIT_PER_PIXEL-1 -: BIT_PER_PIXEL];
    assign bus.pixel_5_blue  = out_win_s[5][BIT_PER_PIXEL-1:0];
    assign bus.pixel_6_red   = out_win_s[6][PW-1 -: BIT_PER_PIXEL];
    assign bus.pixel_6_green = out_win_s[6][2*BIT_PER_PIXEL-1 -: BIT_PER_PIXEL];
    assign bus.pixel_6_blue  = out_win_s[6][BIT_PER_PIXEL-1:0];
    assign bus.pixel_7_red   = out_win_s[7][PW-1 -: BIT_PER_PIXEL];
    assign bus.pixel_7_green = out_win_s[7][2*BIT_PER_PIXEL-1 -: BIT_PER_PIXEL];
    assign bus.pixel_7_blue  = out_win_s[7][BIT_PER_PIXEL-1:0];
    assign bus.pixel_8_red   = out_win_s[8][PW-1 -: BIT_PER_PIXEL];
    assign bus.pixel_8_green = out_win_s[8][2*BIT_PER_PIXEL-1 -: BIT_PER_PIXEL];
    assign bus.pixel_8_blue  = out_win_s[8][BIT_PER_PIXEL-1:0];

endmodule

// File: tb/tb_window_buffer_3x3.sv
// -----------------------------------------------------------------------------
// tb_window_buffer_3x3
//   Directed bench for window_buffer_3x3 with a 4x4 image. Pixel data:
//   red = base + index, green = red + 64, blue = red + 128.
//   Output latency follows WINDOW_OUT_REG_EN.
// -----------------------------------------------------------------------------
module tb_window_buffer_3x3;
    localparam int BPP = 8;
    localparam int W   = 4;
    localparam int H   = 4;
`ifdef WINDOW_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    window_buffer_3x3_if #(.BIT_PER_PIXEL(BPP)) bus ();

    window_buffer_3x3 #(
        .BIT_PER_PIXEL(BPP),
        .IMG_WIDTH    (W),
        .IMG_HEIGHT   (H)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    // Window channels packed so that pixel k sits at bits [k*8 +: 8].
    logic [71:0] obs_red, obs_grn, obs_blu;
    assign obs_red = {bus.pixel_8_red, bus.pixel_7_red, bus.pixel_6_red,
                      bus.pixel_5_red, bus.pixel_4_red, bus.pixel_3_red,
                      bus.pixel_2_red, bus.pixel_1_red, bus.pixel_0_red};
    assign obs_grn = {bus.pixel_8_green, bus.pixel_7_green, bus.pixel_6_green,
                      bus.pixel_5_green, bus.pixel_4_green, bus.pixel_3_green,
                      bus.pixel_2_green, bus.pixel_1_green, bus.pixel_0_green};
    assign obs_blu = {bus.pixel_8_blue, bus.pixel_7_blue, bus.pixel_6_blue,
                      bus.pixel_5_blue, bus.pixel_4_blue, bus.pixel_3_blue,
                      bus.pixel_2_blue, bus.pixel_1_blue, bus.pixel_0_blue};

    int total = 0;
    int bad   = 0;
    int step_no = 0;
    int pstep [0:1][0:15];

    int          wstep [$];
    logic        wlast [$];
    logic [71:0] wred  [$];
    logic [71:0] wgrn  [$];
    logic [71:0] wblu  [$];

    task automatic check(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_q();
        wstep.delete();
        wlast.delete();
        wred.delete();
        wgrn.delete();
        wblu.delete();
    endtask

    // One clock: drive inputs, take the edge, sample 1 time unit later.
    task automatic step(input bit v, input bit sof, input int val);
        bus.in_valid = v;
        bus.in_sof   = sof;
        bus.in_red   = 8'(val);
        bus.in_green = 8'(val + 64);
        bus.in_blue  = 8'(val + 128);
        @(posedge clk);
        #1;
        step_no++;
        if (bus.window_valid === 1'b1) begin
            wstep.push_back(step_no);
            wlast.push_back(bus.window_last);
            wred.push_back(obs_red);
            wgrn.push_back(obs_grn);
            wblu.push_back(obs_blu);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) step(1'b0, 1'b0, 0);
    endtask

    // Send pixels first..last of a frame; remember the step each was accepted.
    task automatic feed(input int slot, input int base, input int first, input int last,
                        input bit sof_first, input bit gaps);
        for (int p = first; p <= last; p++) begin
            step(1'b1, sof_first && (p == first), base + p);
            pstep[slot][p] = step_no;
            if (gaps) idle(1);
        end
    endtask

    // Check the four interior windows of one 4x4 frame starting at queue index q0.
    task automatic check_frame(input string tag, input int q0, input int slot, input int base);
        int rr [4];
        int cc [4];
        rr = '{2, 2, 3, 3};
        cc = '{2, 3, 2, 3};
        check({tag, "_count"}, 72'(wstep.size() >= q0 + 4), 72'(1));
        for (int i = 0; i < 4; i++) begin
            int r;
            int c;
            logic [71:0] er, eg, eb;
            r = rr[i];
            c = cc[i];
            for (int k = 0; k < 9; k++) begin
                int q;
                q = (r - 2 + k / 3) * W + (c - 2 + k % 3);
                er[k*8 +: 8] = 8'(base + q);
                eg[k*8 +: 8] = 8'(base + q + 64);
                eb[k*8 +: 8] = 8'(base + q + 128);
            end
            if (q0 + i < wstep.size()) begin
                check({tag, "_step"}, 72'(wstep[q0+i]), 72'(pstep[slot][r*W+c] + LAT - 1));
                check({tag, "_last"}, 72'(wlast[q0+i]), 72'(i == 3));
                check({tag, "_red"},  wred[q0+i], er);
                check({tag, "_green"}, wgrn[q0+i], eg);
                check({tag, "_blue"}, wblu[q0+i], eb);
            end
        end
    endtask

    initial begin
        logic [71:0] lit_first;
        logic [71:0] lit_last;
        lit_first = {8'd10, 8'd9, 8'd8, 8'd6, 8'd5, 8'd4, 8'd2, 8'd1, 8'd0};
        lit_last  = {8'd15, 8'd14, 8'd13, 8'd11, 8'd10, 8'd9, 8'd7, 8'd6, 8'd5};

        bus.in_valid = 1'b0;
        bus.in_sof   = 1'b0;
        bus.in_red   = 8'd0;
        bus.in_green = 8'd0;
        bus.in_blue  = 8'd0;
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_valid", 72'(bus.window_valid), 72'(0));
        check("reset_last",  72'(bus.window_last),  72'(0));
        check("reset_red",   obs_red, 72'(0));
        check("reset_green", obs_grn, 72'(0));
        check("reset_blue",  obs_blu, 72'(0));
        rst = 1'b0;

        // Continuous frame with sof on pixel 0.
        clear_q();
        feed(0, 0, 0, 15, 1'b1, 1'b0);
        idle(3);
        check("t2_total", 72'(wstep.size()), 72'(4));
        check_frame("t2", 0, 0, 0);
        if (wred.size() >= 4) begin
            check("t2_first_lit", wred[0], lit_first);
            check("t2_last_lit",  wred[3], lit_last);
        end

        // Async reset mid-stream, then a frame without sof.
        clear_q();
        feed(0, 0, 0, 10, 1'b1, 1'b0);
        check("t1_pre_nonzero", 72'(obs_red != 72'(0)), 72'(1));
        #2;
        rst = 1'b1;
        bus.in_valid = 1'b0;
        #1;
        check("t1_async_valid", 72'(bus.window_valid), 72'(0));
        check("t1_async_last",  72'(bus.window_last),  72'(0));
        check("t1_async_red",   obs_red, 72'(0));
        check("t1_async_green", obs_grn, 72'(0));
        check("t1_async_blue",  obs_blu, 72'(0));
        @(posedge clk);
        #1;
        rst = 1'b0;
        clear_q();
        feed(0, 32, 0, 15, 1'b0, 1'b0);
        idle(3);
        check("t1_total", 72'(wstep.size()), 72'(4));
        check_frame("t1", 0, 0, 32);

        // in_valid toggling.
        clear_q();
        feed(0, 64, 0, 15, 1'b1, 1'b1);
        idle(3);
        check("t3_total", 72'(wstep.size()), 72'(4));
        check_frame("t3", 0, 0, 64);
        if (wstep.size() >= 4) begin
            for (int i = 0; i < 3; i++) begin
                check("t3_gap", 72'((wstep[i+1] - wstep[i]) >= 2), 72'(1));
            end
        end

        // sof reasserted on pixel 6: partial frame dropped, restart at (0,0).
        clear_q();
        feed(0, 48, 0, 5, 1'b1, 1'b0);
        check("t4_no_early", 72'(wstep.size()), 72'(0));
        feed(0, 16, 0, 15, 1'b1, 1'b0);
        idle(3);
        check("t4_total", 72'(wstep.size()), 72'(4));
        check_frame("t4", 0, 0, 16);

        // Two back-to-back frames, sof only on the first.
        clear_q();
        feed(0, 0, 0, 15, 1'b1, 1'b0);
        feed(1, 16, 0, 15, 1'b0, 1'b0);
        idle(3);
        check("t5_total", 72'(wstep.size()), 72'(8));
        check_frame("t5a", 0, 0, 0);
        check_frame("t5b", 4, 1, 16);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
